// File: rtl/cordic_rot_sched.sv
// cordic_rot_sched: two-requester front end for a shared, non-stallable
// pipelined CORDIC rotation core. Incoming angles are folded into +/-90 deg,
// one operation issues per cycle under round-robin arbitration, and results
// return to per-requester FWFT FIFOs. Credits bound the in-flight work so that
// no FIFO can ever overflow.
module cordic_rot_sched #(
  parameter int N        = 16,
  parameter int CORE_LAT = 16,
  parameter int DEPTH    = 4,
  parameter int ANG_HALF = 18000,
  parameter int ANG_QTR  = 9000
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic signed [N-1:0] req0_x,
  input  logic signed [N-1:0] req0_y,
  input  logic signed [N-1:0] req0_angle,

  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic signed [N-1:0] req1_x,
  input  logic signed [N-1:0] req1_y,
  input  logic signed [N-1:0] req1_angle,

  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic signed [N-1:0] rsp0_x,
  output logic signed [N-1:0] rsp0_y,

  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic signed [N-1:0] rsp1_x,
  output logic signed [N-1:0] rsp1_y,

  output logic signed [N-1:0] core_x,
  output logic signed [N-1:0] core_y,
  output logic signed [N-1:0] core_angle,
  input  logic signed [N-1:0] core_xr,
  input  logic signed [N-1:0] core_yr,

  output logic                busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic signed [N-1:0] QTR      = N'(ANG_QTR);
  localparam logic signed [N-1:0] HALF     = N'(ANG_HALF);
  localparam logic [CW-1:0]       CRED_MAX = CW'(DEPTH);
  localparam logic [CW-1:0]       CRED_ONE = CW'(1);
  localparam logic [AW:0]         PTR_ONE  = (AW + 1)'(1);

  typedef enum logic {PREF0 = 1'b0, PREF1 = 1'b1} pref_t;

  // Two's-complement negation, clamping the most negative value.
  function automatic logic signed [N-1:0] neg_sat(input logic signed [N-1:0] v);
    logic signed [N-1:0] min_v;
    min_v = {1'b1, {(N-1){1'b0}}};
    return (v == min_v) ? ~v : -v;
  endfunction

  pref_t          pref, pref_next;
  logic [CW-1:0]  credit0, credit1;
  logic           elig0, elig1;
  logic           acc0, acc1, acc_any;
  logic           pop0, pop1;

  logic signed [N-1:0] sel_x, sel_y, sel_a;
  logic signed [N-1:0] fold_x, fold_y, fold_a;

  logic [CORE_LAT:0] tag_v;
  logic [CORE_LAT:0] tag_o;
  logic              exit_v, exit_o;
  logic [1:0]        fifo_wr;
  logic [1:0]        fifo_pop;
  logic [1:0]        fifo_valid;
  logic [1:0][N-1:0] head_x;
  logic [1:0][N-1:0] head_y;

  // Eligibility, ready and accept strobes; ready is held low while in reset.
  always_comb begin
    elig0      = req0_valid & (credit0 != '0);
    elig1      = req1_valid & (credit1 != '0);
    req0_ready = rst & (credit0 != '0) & ((pref == PREF0) | ~elig1);
    req1_ready = rst & (credit1 != '0) & ((pref == PREF1) | ~elig0);
    acc0       = req0_valid & req0_ready;
    acc1       = req1_valid & req1_ready;
    acc_any    = acc0 | acc1;
  end

  // Round-robin pointer: after a grant, prefer the other requester.
  always_comb begin
    pref_next = pref;
    if (acc0)      pref_next = PREF1;
    else if (acc1) pref_next = PREF0;
  end

  // Pointer state register.
  always_ff @(posedge clk) begin
    if (!rst) pref <= PREF0;
    else      pref <= pref_next;
  end

  // Credit counters: accept consumes, pop returns, both together cancel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      credit0 <= CRED_MAX;
      credit1 <= CRED_MAX;
    end else begin
      case ({acc0, pop0})
        2'b10:   credit0 <= credit0 - CRED_ONE;
        2'b01:   credit0 <= credit0 + CRED_ONE;
        default: credit0 <= credit0;
      endcase
      case ({acc1, pop1})
        2'b10:   credit1 <= credit1 - CRED_ONE;
        2'b01:   credit1 <= credit1 + CRED_ONE;
        default: credit1 <= credit1;
      endcase
    end
  end

  // Select the granted operand and fold its angle into +/-90 deg.
  always_comb begin
    sel_x  = acc1 ? req1_x     : req0_x;
    sel_y  = acc1 ? req1_y     : req0_y;
    sel_a  = acc1 ? req1_angle : req0_angle;
    fold_x = sel_x;
    fold_y = sel_y;
    fold_a = sel_a;
    if (sel_a > QTR) begin
      fold_a = sel_a - HALF;
      fold_x = neg_sat(sel_x);
      fold_y = neg_sat(sel_y);
    end else if (sel_a < -QTR) begin
      fold_a = sel_a + HALF;
      fold_x = neg_sat(sel_x);
      fold_y = neg_sat(sel_y);
    end
  end

  // Core operand registers; they hold their value when nothing issues.
  always_ff @(posedge clk) begin
    if (!rst) begin
      core_x     <= '0;
      core_y     <= '0;
      core_angle <= '0;
    end else if (acc_any) begin
      core_x     <= fold_x;
      core_y     <= fold_y;
      core_angle <= fold_a;
    end
  end

  // Tag pipeline shadowing the core: valid plus owner per in-flight op.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      tag_v <= {tag_v[CORE_LAT-1:0], acc_any};
      tag_o <= {tag_o[CORE_LAT-1:0], acc1};
    end
  end

  // Route the core result leaving the last tag slot to its owner's FIFO.
  always_comb begin
    exit_v      = tag_v[CORE_LAT];
    exit_o      = tag_o[CORE_LAT];
    fifo_wr[0]  = exit_v & ~exit_o;
    fifo_wr[1]  = exit_v & exit_o;
    fifo_pop[0] = rsp0_ready & fifo_valid[0];
    fifo_pop[1] = rsp1_ready & fifo_valid[1];
    pop0        = fifo_pop[0];
    pop1        = fifo_pop[1];
  end

  for (genvar k = 0; k < 2; k++) begin : g_fifo
    logic [N-1:0] mem_x [DEPTH];
    logic [N-1:0] mem_y [DEPTH];
    logic [AW:0]  wp, rp;

    // Result storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
      if (fifo_wr[k]) begin
        mem_x[wp[AW-1:0]] <= core_xr;
        mem_y[wp[AW-1:0]] <= core_yr;
      end
    end

    // Wrapping pointers with an extra lap bit to tell full from empty.
    always_ff @(posedge clk) begin
      if (!rst) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (fifo_wr[k])  wp <= wp + PTR_ONE;
        if (fifo_pop[k]) rp <= rp + PTR_ONE;
      end
    end

    assign fifo_valid[k] = (wp != rp);
    assign head_x[k]     = mem_x[rp[AW-1:0]];
    assign head_y[k]     = mem_y[rp[AW-1:0]];
  end

  assign rsp0_valid = fifo_valid[0];
  assign rsp1_valid = fifo_valid[1];
  assign rsp0_x     = head_x[0];
  assign rsp0_y     = head_y[0];
  assign rsp1_x     = head_x[1];
  assign rsp1_y     = head_y[1];

  assign busy = (|tag_v) | fifo_valid[0] | fifo_valid[1];

endmodule

// File: doc/cordic_rot_sched.md
Name: cordic_rot_sched

Overview:
- Shares one pipelined CORDIC rotation core between two requesters (req0, req1), one issue per cycle.
- Folds input angles into the core's convergence range (±90.00°) before issue.
- Tracks in-flight operations with a tag pipeline and routes each core result into the owning requester's result FIFO.
- Credit-based issue ensures the non-stallable core never overruns a FIFO.
- Sits between the angle/vector producers and the rotation core.

Parameters:
- N, 16, data/angle width (signed, angle unit = 0.01 degree).
- CORE_LAT, 16, core latency in clocks from its input to its output (= core STAGE count).
- DEPTH, 4, per-requester result FIFO depth (power of 2, ≥2).
- ANG_HALF, 18000, 180.00° in angle units.
- ANG_QTR, 9000, 90.00° in angle units.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- reqK_valid  in  1  requester K (K=0,1) operand valid
- reqK_ready  out  1  requester K accepted this cycle when valid&ready
- reqK_x, reqK_y  in  N  signed input vector
- reqK_angle  in  N  signed rotation angle, legal range -18000..18000
- rspK_valid  out  1  result available in FIFO K
- rspK_ready  in  1  consumer K pops when valid&ready
- rspK_x, rspK_y  out  N  result vector at FIFO K head
- core_x, core_y, core_angle  out  N  registered operands to core
- core_xr, core_yr  in  N  core result, valid CORE_LAT cycles after core inputs change
- busy  out  1  any op in flight or any FIFO non-empty

Behaviour:
- Reset (rst=0 at edge):
  - core_x/core_y/core_angle = 0; tag pipeline cleared; FIFOs emptied.
  - creditK = DEPTH; round-robin pointer = req0 preferred.
  - rspK_valid = 0, busy = 0; reqK_ready low during reset.
  - Results of ops in flight at reset are discarded, never written.
- Credit:
  - creditK decrements on accept K and increments on pop K; both in the same cycle leaves it unchanged.
  - Range 0..DEPTH. Eligible K = reqK_valid & (creditK > 0).
- Arbitration:
  - At most one accept per cycle.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the preferred one is granted; after any grant the pointer prefers the other requester.
  - reqK_ready = creditK>0 & (K preferred | other not eligible). This is combinational from valid; a requester may hold valid across cycles without penalty.
- Angle fold (on accept, registered into core_* at the accepting edge):
  - angle in [-ANG_QTR, ANG_QTR]: operands pass unchanged.
  - angle > ANG_QTR: core_angle = angle - ANG_HALF, core_x = -x, core_y = -y.
  - angle < -ANG_QTR: core_angle = angle + ANG_HALF, x and y negated.
  - Negation saturates: -(-2^(N-1)) = 2^(N-1)-1.
  - Angles outside ±ANG_HALF: result unspecified, no lockup.
- Idle: core_* hold their last value; no tag is inserted.
- Tag pipeline:
  - CORE_LAT+1 entries of {valid, owner}; entry inserted at the accept edge.
  - When an entry reaches the last position, core_xr/core_yr are written into FIFO[owner] at the next edge.
- Latency:
  - Accept at edge E0 → result written at edge E0+CORE_LAT+1.
  - For an empty FIFO, rspK_valid goes high after that edge: 17 cycles at defaults.
  - Throughput: 1 op/cycle aggregate.
- FIFOs:
  - First-word-fall-through, DEPTH entries, independent pointers with wrap.
  - Write and pop in the same cycle are allowed, including on a full FIFO, since credit reserves space.
  - Overflow is impossible by construction; the bench asserts it.
  - Ordering per requester is preserved.
- busy = |tag valids | rsp0_valid | rsp1_valid.

Test Plan:
- Single op: req0 x=10000, y=0, angle=3000 → next cycle core_x=10000, core_y=0, core_angle=3000; rsp0_valid rises exactly 17 cycles after accept; rsp0_x/y equal core_xr/yr sampled at the tag-exit cycle.
- Fold: req1 x=1000, y=2000, angle=12000 → core sees (-1000, -2000, -6000). angle=-15000 → core_angle=3000, negated vector. x=-32768 → core_x=32767.
- Arbitration: both valid continuously, rsp ready high → grants alternate 0,1,0,1…; one accept per cycle; each FIFO receives only its own results, in order.
- Backpressure, DEPTH=4: rsp0_ready=0, req0 always valid → exactly 4 req0 accepts, then req0_ready=0 while req1 keeps 1 accept/cycle. Pop one from rsp0 → exactly one more req0 accept.
- Simultaneous pop+accept on credit 0 boundary → credit unchanged, no overflow, no lost result.
- Reset mid-flight: 5 ops in flight, rst=0 one cycle → rsp*_valid=0, busy=0, credits=4, no stale result appears in the following CORE_LAT+2 cycles; a new op then completes normally.
